cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 60 ++++++
 rtl/cdb_src_fifo.sv | 82 ++++++++
 rtl/cdb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_pkg
// Description : Shared constants, result record and round-robin helper for
//               the common-data-bus arbiter and its per-source FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_pkg;

    // Number of result producers competing for the bus
    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;

    // Source indices, also the value broadcast on CDB_src
    localparam logic [SRC_W-1:0] SRC_INT    = 2'd0;
    localparam logic [SRC_W-1:0] SRC_MULT   = 2'd1;
    localparam logic [SRC_W-1:0] SRC_DIV    = 2'd2;
    localparam logic [SRC_W-1:0] SRC_LD_BUF = 2'd3;

    // Occupancy counter width; wide enough for the deepest legal FIFO (8)
    localparam int CNT_W = 4;

    // Default widths of the broadcast record
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 6;

    // One buffered/broadcast result at the default widths.  The RTL stores
    // the same {data, tag} packing as a flat vector so that the width
    // parameters of the arbiter stay overridable.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_TAG_WIDTH-1:0]  tag;
    } cdb_result_t;

    // Outcome of one arbitration round
    typedef struct packed {
        logic             found;
        logic [SRC_W-1:0] idx;
    } grant_t;

    // Round-robin pick: first requesting source at or after rr, wrapping.
    // The loop walks the offsets from farthest to nearest so that the
    // nearest requester is the last one written and therefore wins.
    function automatic grant_t rr_pick(input logic [NUM_SRC-1:0] cand,
                                       input logic [SRC_W-1:0]   rr);
        grant_t           g;
        logic [SRC_W-1:0] idx;
        g = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = rr + SRC_W'(i);
            if (cand[idx]) begin
                g.found = 1'b1;
                g.idx   = idx;
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_src_fifo
// Description : Small per-source result queue in front of the CDB arbiter.
//               Accepts a push while full only when a pop happens in the
//               same cycle; flush empties it and overrides push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W-1:0] w_wr_next;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full queue can still take
    // the incoming result when its head leaves.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointers wrap at DEPTH, which need not be a power of two
    assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
    assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (reset && !flush && w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin common-data-bus arbiter for the int, mult, div
//               and load-buffer result sources.  Each source has a small
//               FIFO; a live result with an empty FIFO may bypass straight
//               onto the registered bus.  Lost results raise a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,

    input  logic                  int_valid,
    input  logic [DATA_WIDTH-1:0] int_data,
    input  logic [TAG_WIDTH-1:0]  int_tag,
    output logic                  int_stall,

    input  logic                  mult_valid,
    input  logic [DATA_WIDTH-1:0] mult_data,
    input  logic [TAG_WIDTH-1:0]  mult_tag,
    output logic                  mult_stall,

    input  logic                  div_valid,
    input  logic [DATA_WIDTH-1:0] div_data,
    input  logic [TAG_WIDTH-1:0]  div_tag,
    output logic                  div_stall,

    input  logic                  ld_buf_valid,
    input  logic [DATA_WIDTH-1:0] ld_buf_data,
    input  logic [TAG_WIDTH-1:0]  ld_buf_tag,
    output logic                  ld_buf_stall,

    output logic                  CDB_valid,
    output logic [DATA_WIDTH-1:0] CDB_data,
    output logic [TAG_WIDTH-1:0]  CDB_tag,
    output logic [1:0]            CDB_src,
    output logic                  overflow_err
);

    // Flat {data, tag} record, same packing as cdb_result_t
    localparam int RES_W = DATA_WIDTH + TAG_WIDTH;

    // Per-source views of the inputs, indexed by the SRC_* constants
    logic [NUM_SRC-1:0] w_in_valid;
    logic [RES_W-1:0]   w_in_res   [NUM_SRC];

    // FIFO interface
    logic [RES_W-1:0]   w_head     [NUM_SRC];
    logic [CNT_W-1:0]   w_count    [NUM_SRC];
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;

    // Arbitration
    logic [NUM_SRC-1:0] w_cand_valid;
    logic [RES_W-1:0]   w_cand_res [NUM_SRC];
    logic [NUM_SRC-1:0] w_sel;
    logic [NUM_SRC-1:0] w_bypass;
    logic [NUM_SRC-1:0] w_drop;
    logic [NUM_SRC-1:0] w_stall;
    grant_t             w_gnt;
    logic [RES_W-1:0]   w_win_res;

    // Registered state
    logic [SRC_W-1:0]      r_rr;
    logic                  r_cdb_valid;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [TAG_WIDTH-1:0]  r_cdb_tag;
    logic [SRC_W-1:0]      r_cdb_src;
    logic                  r_overflow;

    assign w_in_valid = {ld_buf_valid, div_valid, mult_valid, int_valid};

    assign w_in_res[SRC_INT]    = {int_data,    int_tag};
    assign w_in_res[SRC_MULT]   = {mult_data,   mult_tag};
    assign w_in_res[SRC_DIV]    = {div_data,    div_tag};
    assign w_in_res[SRC_LD_BUF] = {ld_buf_data, ld_buf_tag};

    // One queue plus candidate / bypass / push / pop decode per source
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        localparam logic [SRC_W-1:0] c_idx = SRC_W'(gi);

        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (RES_W)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .push      (w_push[gi]),
            .pop       (w_pop[gi]),
            .push_data (w_in_res[gi]),
            .head      (w_head[gi]),
            .count     (w_count[gi]),
            .full      (w_full[gi]),
            .empty     (w_empty[gi])
        );

        // The oldest buffered result always goes first; the live input is
        // only a candidate when nothing is waiting ahead of it.
        assign w_cand_valid[gi] = !w_empty[gi] || w_in_valid[gi];
        assign w_cand_res[gi]   = w_empty[gi] ? w_in_res[gi] : w_head[gi];

        assign w_sel[gi]    = w_gnt.found && (w_gnt.idx == c_idx);
        assign w_bypass[gi] = w_sel[gi] && w_empty[gi] && w_in_valid[gi];

        // Flush discards this cycle's inputs and freezes the queues
        assign w_push[gi] = w_in_valid[gi] && !w_bypass[gi] && !flush;
        assign w_pop[gi]  = w_sel[gi] && !w_empty[gi] && !flush;

        // A result is lost only when it has nowhere to go this cycle
        assign w_drop[gi] = w_push[gi] && w_full[gi] && !w_pop[gi];

        // Early warning one entry before full, from registered count only
        assign w_stall[gi] = (w_count[gi] >= CNT_W'(FIFO_DEPTH - 1));
    end

    assign int_stall    = w_stall[SRC_INT];
    assign mult_stall   = w_stall[SRC_MULT];
    assign div_stall    = w_stall[SRC_DIV];
    assign ld_buf_stall = w_stall[SRC_LD_BUF];

    assign w_gnt     = rr_pick(w_cand_valid, r_rr);
    assign w_win_res = w_cand_res[w_gnt.idx];

    // Round-robin pointer moves past the winner; held on idle and flush
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr <= SRC_INT;
        end else if (!flush && w_gnt.found) begin
            r_rr <= w_gnt.idx + SRC_W'(1);
        end
    end

    // Registered broadcast; idle and flushed cycles drive an all-zero bus
    always_ff @(posedge clk) begin
        if (!reset || flush || !w_gnt.found) begin
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_tag   <= '0;
            r_cdb_src   <= '0;
        end else begin
            r_cdb_valid <= 1'b1;
            r_cdb_data  <= w_win_res[RES_W-1:TAG_WIDTH];
            r_cdb_tag   <= w_win_res[TAG_WIDTH-1:0];
            r_cdb_src   <= w_gnt.idx;
        end
    end

    // Sticky loss indicator, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (|w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign CDB_valid    = r_cdb_valid;
    assign CDB_data     = r_cdb_data;
    assign CDB_tag      = r_cdb_tag;
    assign CDB_src      = r_cdb_src;
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Scoreboard bench for cdb_arbiter.  A queue-based reference
//               model predicts each broadcast; a negedge monitor matches
//               them against the bus cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          flush;
    logic [3:0]    drv_v;
    logic [DW-1:0] drv_d [4];
    logic [TW-1:0] drv_t [4];

    logic          int_valid, mult_valid, div_valid, ld_buf_valid;
    logic [DW-1:0] int_data, mult_data, div_data, ld_buf_data;
    logic [TW-1:0] int_tag, mult_tag, div_tag, ld_buf_tag;
    logic          int_stall, mult_stall, div_stall, ld_buf_stall;
    logic          CDB_valid;
    logic [DW-1:0] CDB_data;
    logic [TW-1:0] CDB_tag;
    logic [1:0]    CDB_src;
    logic          overflow_err;

    assign int_valid    = drv_v[0];
    assign mult_valid   = drv_v[1];
    assign div_valid    = drv_v[2];
    assign ld_buf_valid = drv_v[3];
    assign int_data     = drv_d[0];
    assign mult_data    = drv_d[1];
    assign div_data     = drv_d[2];
    assign ld_buf_data  = drv_d[3];
    assign int_tag      = drv_t[0];
    assign mult_tag     = drv_t[1];
    assign div_tag      = drv_t[2];
    assign ld_buf_tag   = drv_t[3];

    cdb_arbiter #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .int_valid    (int_valid),
        .int_data     (int_data),
        .int_tag      (int_tag),
        .int_stall    (int_stall),
        .mult_valid   (mult_valid),
        .mult_data    (mult_data),
        .mult_tag     (mult_tag),
        .mult_stall   (mult_stall),
        .div_valid    (div_valid),
        .div_data     (div_data),
        .div_tag      (div_tag),
        .div_stall    (div_stall),
        .ld_buf_valid (ld_buf_valid),
        .ld_buf_data  (ld_buf_data),
        .ld_buf_tag   (ld_buf_tag),
        .ld_buf_stall (ld_buf_stall),
        .CDB_valid    (CDB_valid),
        .CDB_data     (CDB_data),
        .CDB_tag      (CDB_tag),
        .CDB_src      (CDB_src),
        .overflow_err (overflow_err)
    );

    // Expected broadcast: which cycle it must appear in, and what it carries
    typedef struct {
        int          cyc;
        cdb_result_t res;
        logic [1:0]  src;
    } exp_t;

    exp_t        sb [$];
    cdb_result_t mq [4][$];   // model of each source's waiting results
    int          m_rr;
    bit          m_ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: matches the bus against the scoreboard in the sampled cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL cdb_stale: expected tag %0h never broadcast (due cycle %0d, now %0d)",
                         sb[0].res.tag, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (CDB_valid === 1'b1) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL cdb_unexpected: got src %0d tag %0h expected no broadcast at cycle %0d",
                             CDB_src, CDB_tag, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cdb_data", 64'(CDB_data), 64'(e.res.data));
                    chk("cdb_tag",  64'(CDB_tag),  64'(e.res.tag));
                    chk("cdb_src",  64'(CDB_src),  64'(e.src));
                end
            end else begin
                chk("cdb_valid_idle", 64'(CDB_valid), 64'(0));
                chk("cdb_idle_zero", 64'({CDB_data, CDB_tag, CDB_src}), 64'(0));
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    total++;
                    bad++;
                    $display("FAIL cdb_missing: got idle expected src %0d tag %0h at cycle %0d",
                             sb[0].src, sb[0].res.tag, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic set_idle();
        drv_v = '0;
        for (int i = 0; i < 4; i++) begin
            drv_d[i] = $urandom;
            drv_t[i] = TW'($urandom);
        end
    endtask

    // Apply current drv_* for one clock, advance the model, check side outputs
    task automatic step(input bit rs, input bit fl);
        cdb_result_t live [4];
        bit          found;
        int          k;
        bit          byp;
        reset = rs ? 1'b0 : 1'b1;
        flush = fl;
        for (int i = 0; i < 4; i++) live[i] = '{data: drv_d[i], tag: drv_t[i]};
        if (rs) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_rr  = 0;
            m_ovf = 1'b0;
        end else if (fl) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
        end else begin
            found = 1'b0;
            k     = 0;
            for (int i = 0; i < 4; i++) begin
                int s;
                s = (m_rr + i) % 4;
                if (!found && (mq[s].size() > 0 || drv_v[s])) begin
                    found = 1'b1;
                    k     = s;
                end
            end
            if (found) begin
                exp_t e;
                e.cyc = cyc + 1;
                e.src = 2'(k);
                e.res = (mq[k].size() > 0) ? mq[k][0] : live[k];
                sb.push_back(e);
                m_rr = (k + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                byp = found && (k == i) && (mq[i].size() == 0);
                if (found && k == i && mq[i].size() > 0) void'(mq[i].pop_front());
                if (drv_v[i] && !byp) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back(live[i]);
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("int_stall",    64'(int_stall),    64'(mq[0].size() >= DEPTH - 1));
        chk("mult_stall",   64'(mult_stall),   64'(mq[1].size() >= DEPTH - 1));
        chk("div_stall",    64'(div_stall),    64'(mq[2].size() >= DEPTH - 1));
        chk("ld_buf_stall", 64'(ld_buf_stall), 64'(mq[3].size() >= DEPTH - 1));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            step(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        set_idle();
        step(1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int load;
        flush = 1'b0;
        set_idle();
        step(1'b1, 1'b0);
        mon_en = 1'b1;
        do_reset();
        chk("reset_valid", 64'(CDB_valid), 64'(0));
        chk("reset_ovf",   64'(overflow_err), 64'(0));

        // Single int result bypasses onto the bus one cycle later
        set_idle();
        drv_v[0] = 1'b1;
        drv_t[0] = 6'd5;
        drv_d[0] = 32'hA5A5_A5A5;
        step(1'b0, 1'b0);
        chk("single_valid", 64'(CDB_valid), 64'(1));
        chk("single_tag",   64'(CDB_tag),   64'(5));
        chk("single_src",   64'(CDB_src),   64'(0));
        chk("single_data",  64'(CDB_data),  64'(32'hA5A5_A5A5));
        chk("single_int_empty", 64'(int_stall), 64'(0));
        idle_cycles(2);

        // All four at once: granted int, mult, div, ld_buf in turn
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv_v[i] = 1'b1;
            drv_t[i] = TW'(10 + i);
        end
        step(1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            chk("all4_src", 64'(CDB_src), 64'(j));
            chk("all4_tag", 64'(CDB_tag), 64'(10 + j));
            set_idle();
            step(1'b0, 1'b0);
        end
        chk("all4_tail_idle", 64'(CDB_valid), 64'(0));

        // div and int contending for three cycles: int stalls but nothing lost
        do_reset();
        for (int j = 0; j < 3; j++) begin
            set_idle();
            drv_v[0] = 1'b1;
            drv_v[2] = 1'b1;
            drv_t[0] = TW'(20 + j);
            drv_t[2] = TW'(30 + j);
            step(1'b0, 1'b0);
            if (j == 1) chk("contend_int_stall", 64'(int_stall), 64'(1));
        end
        idle_cycles(6);
        chk("contend_no_ovf", 64'(overflow_err), 64'(0));

        // Everyone busy for four cycles: some queue must overflow
        do_reset();
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                drv_v[i] = 1'b1;
                drv_d[i] = $urandom;
                drv_t[i] = TW'(4 * j + i + 32);
            end
            step(1'b0, 1'b0);
        end
        chk("busy_ovf_set", 64'(overflow_err), 64'(1));
        idle_cycles(10);
        chk("busy_ovf_sticky", 64'(overflow_err), 64'(1));

        // Fill several queues, then flush
        do_reset();
        for (int j = 0; j < 3; j++) begin
            set_idle();
            drv_v = 4'b1011;
            step(1'b0, 1'b0);
        end
        set_idle();
        drv_v = 4'b1111;
        step(1'b0, 1'b1);
        chk("flush_valid", 64'(CDB_valid), 64'(0));
        chk("flush_stalls", 64'({int_stall, mult_stall, div_stall, ld_buf_stall}), 64'(0));
        set_idle();
        drv_v = 4'b1111;
        step(1'b0, 1'b0);
        idle_cycles(5);

        // Reset in the middle of a four-way burst, then a lone ld_buf result
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv_v[i] = 1'b1;
            drv_t[i] = TW'(40 + i);
        end
        step(1'b0, 1'b0);
        idle_cycles(1);
        do_reset();
        chk("midrst_outputs", 64'({CDB_valid, CDB_data, CDB_tag, CDB_src, overflow_err}), 64'(0));
        set_idle();
        drv_v[3] = 1'b1;
        drv_t[3] = 6'd50;
        step(1'b0, 1'b0);
        chk("midrst_ld_first", 64'({CDB_valid, CDB_src}), 64'({1'b1, 2'd3}));
        idle_cycles(4);

        // Randomized traffic with varying load, occasional flush and reset
        load = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 64 == 0) load = $urandom_range(5, 95);
            for (int i = 0; i < 4; i++) begin
                drv_v[i] = ($urandom_range(0, 99) < load);
                drv_d[i] = $urandom;
                drv_t[i] = TW'($urandom);
            end
            if ($urandom_range(0, 149) == 0) step(1'b1, 1'b0);
            else step(1'b0, ($urandom_range(0, 39) == 0));
        end

        idle_cycles(12);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
